apb_rr_master_arbiter: RTL and testbench
========================================

Name: apb_rr_master_arbiter

Overview:
- APB4 master that shares one APB slave port between NREQ local requesters, e.g. the board-control sequencer and the debug/UART bridge.
- Arbitrates round-robin and sequences the IDLE → SETUP → ACCESS protocol.
- Waits on PREADY and returns read data and error status to the granted requester.
- Sits between the requester logic and the APB register/memory slave on the Arty A7 design.

Parameters:
- AW, 32, address width
- DW, 32, data width
- SW, 4, strobe width (DW/8)
- NREQ, 2, number of requesters (≥2)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout
- PROT_VAL, 3'b000, constant driven on PPROT

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-cycle accept pulse, one-hot
- req_write  in  NREQ  1 = write
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_strb  in  NREQ*SW  packed byte strobes
- rsp_valid  out  NREQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  DW  read data, shared, valid with rsp_valid
- rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
- PADDR  out  AW, PPROT  out  3, PNSE  out  1, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  DW, PSTRB  out  SW  APB master outputs
- PRDATA  in  DW, PREADY  in  1, PSLVERR  in  1  APB slave responses

Behaviour:
- Reset values: all outputs 0; PPROT = PROT_VAL. State = IDLE, rr pointer last_grant = NREQ-1 so requester 0 wins first. Async reset mid-transfer aborts the transfer with no rsp_valid.
- State IDLE (PSEL=0, PENABLE=0):
  - If any req_valid, grant g = first set bit searching from last_grant+1 with wrap.
  - req_ready[g]=1 this cycle (combinational from registered state + req_valid).
  - Latch addr/write/wdata/strb into command regs; last_grant<=g; next SETUP.
- State SETUP (PSEL=1, PENABLE=0): PREADY ignored; always next ACCESS.
- State ACCESS (PSEL=1, PENABLE=1):
  - Sample PREADY each cycle.
  - On PREADY=1: capture PRDATA (reads only; writes leave rsp_rdata=0) and PSLVERR; next IDLE.
  - Timeout: if TIMEOUT≠0 and wait counter reaches TIMEOUT with PREADY=0, next IDLE with rsp_err=1, rsp_rdata=0.
- APB signal stability: PADDR, PWRITE, PWDATA, PSTRB driven from command regs and held constant from SETUP through the last ACCESS cycle. PSTRB forced 0 on reads. PNSE=0. PADDR/PWDATA keep last value in IDLE.
- Latency:
  - Accept at cycle T, SETUP T+1, ACCESS from T+2.
  - PREADY seen at T+k gives rsp_valid[g], rsp_rdata, rsp_err registered at T+k+1 for exactly one cycle.
  - Minimum accept-to-response is 3 cycles. No back-to-back transfers: IDLE is re-entered between transfers, so the next accept can occur in the rsp_valid cycle.
- Wait counter: width $clog2(TIMEOUT+1). Cleared on entering ACCESS. Saturates and never wraps.
- Requester rules:
  - req_valid must hold until req_ready.
  - Dropping req_valid before grant is legal and causes no transfer.
  - req_valid high during rsp_valid is a new request.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NREQ-1,0. A lone requester is granted every transfer.

Decomposition:
- Shared package apb_pkg holds:
  - apb_state_t (IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100)
  - apb_cmd_t struct {addr, write, wdata, strb}
  - localparams for the APB register map base 32'h4000_1000
- Sub-module apb_rr_grant is combinational. Inputs: req vector, last_grant. Outputs: one-hot grant, grant index, any.

Test Plan:
- Req0 write 0x4000_1010 data 0xDEADBEEF strb 4'hF, then read same address → PWRITE/PADDR stable across SETUP+ACCESS; read rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3+wait cycles after req_ready.
- Req0 and req1 assert together, each issues 3 reads of 0x4000_100C → grant order 0,1,0,1,0,1; all rsp_rdata=0xA735_0001; req_ready and rsp_valid one-hot.
- Write 0x4000_1004 with strb 4'h0 then read → APB PSTRB=0 on the write; read transfer also shows PSTRB=0.
- Read 0x5000_0000 (out of range) → slave PSLVERR=1 gives rsp_err=1; next transfer to 0x4000_1010 gives rsp_err=0.
- Slave PREADY tied 0, TIMEOUT=16 → exactly 16 ACCESS cycles, then PSEL=0 and rsp_valid with rsp_err=1, rsp_rdata=0; TIMEOUT=0 → stays in ACCESS indefinitely.
- Assert PRESETn low during ACCESS → PSEL/PENABLE/rsp_valid 0 immediately; after release, pending req1 is granted before req0.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB round-robin master
//
// Contents:
//   apb_state_t  one-hot APB master sequencer state (IDLE / SETUP / ACCESS)
//   apb_cmd_t    latched command: address, direction, write data, byte strobes
//   APB_*        default bus widths and the register-map window of the slave
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = APB_DW / 8;

    // Register/memory slave window on the board.
    localparam logic [31:0] APB_REG_BASE = 32'h4000_1000;
    localparam logic [31:0] APB_REG_SIZE = 32'h0000_1000;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } apb_state_t;

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic              write;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_rr_grant.sv
// rtl/apb_rr_grant.sv - combinational round-robin grant selection
//
// Ports:
//   req         in   NREQ  request vector
//   last_grant  in   IW    index of the most recent grant (search starts after it)
//   grant       out  NREQ  one-hot grant, all zero when nothing requests
//   grant_idx   out  IW    index of the granted requester (last_grant when none)
//   any         out  1     at least one requester is asking
module apb_rr_grant
    import apb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    // Walk the requesters starting one past the previous winner and take the
    // first one asking; the previous winner itself is checked last.
    always_comb begin : p_search
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = last_grant;
        any       = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// rtl/apb_rr_master_arbiter.sv - APB4 master shared round-robin between NREQ requesters
//
// Ports:
//   PCLK, PRESETn             APB clock, asynchronous active-low reset
//   req_valid/req_ready       per-requester command handshake (ready is a one-hot pulse)
//   req_write/addr/wdata/strb packed per-requester command fields
//   rsp_valid                 one-hot completion pulse to the owning requester
//   rsp_rdata, rsp_err        shared response, valid with rsp_valid
//   PADDR..PSTRB              APB master outputs
//   PRDATA, PREADY, PSLVERR   APB slave responses
module apb_rr_master_arbiter
    import apb_pkg::*;
#(
    parameter int         AW       = APB_AW,
    parameter int         DW       = APB_DW,
    parameter int         SW       = APB_SW,
    parameter int         NREQ     = 2,
    parameter int         TIMEOUT  = 16,
    parameter logic [2:0] PROT_VAL = 3'b000
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*SW-1:0] req_strb,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic [AW-1:0]     PADDR,
    output logic [2:0]        PPROT,
    output logic              PNSE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DW-1:0]     PWDATA,
    output logic [SW-1:0]     PSTRB,
    input  logic [DW-1:0]     PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_LIM);

    apb_state_t state, state_nxt;

    logic [IW-1:0]   last_grant;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] owner_oh;

    logic [AW-1:0]   cmd_addr;
    logic            cmd_write;
    logic [DW-1:0]   cmd_wdata;
    logic [SW-1:0]   cmd_strb;

    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;

    apb_rr_grant #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_grant (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    // The transfer in flight always belongs to last_grant, since it is
    // updated at accept time.
    always_comb begin
        owner_oh             = '0;
        owner_oh[last_grant] = 1'b1;
    end

    // wait_cnt holds the number of completed ACCESS cycles, so the abort
    // fires on the TIMEOUT-th ACCESS cycle that still sees PREADY low.
    assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !PREADY
                         && (wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, grant pointer, wait counter and response registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant <= IW'(NREQ - 1);
            cmd_addr   <= '0;
            cmd_write  <= 1'b0;
            cmd_wdata  <= '0;
            cmd_strb   <= '0;
            wait_cnt   <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;

            if (state == IDLE && grant_any) begin
                last_grant <= grant_idx;
                cmd_addr   <= req_addr[int'(grant_idx)*AW +: AW];
                cmd_write  <= req_write[grant_idx];
                cmd_wdata  <= req_wdata[int'(grant_idx)*DW +: DW];
                cmd_strb   <= req_strb[int'(grant_idx)*SW +: SW];
            end

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_valid <= owner_oh;
                    rsp_rdata <= cmd_write ? '0 : PRDATA;
                    rsp_err   <= PSLVERR;
                end else if (timeout_hit) begin
                    rsp_valid <= owner_oh;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

    // Outputs: APB control from state, APB payload straight from the command
    // registers so it stays constant from SETUP through the last ACCESS.
    always_comb begin
        req_ready = (state == IDLE) ? grant : '0;
        PSEL      = (state != IDLE);
        PENABLE   = (state == ACCESS);
        PADDR     = cmd_addr;
        PWRITE    = cmd_write;
        PWDATA    = cmd_wdata;
        PSTRB     = cmd_write ? cmd_strb : '0;
        PPROT     = PROT_VAL;
        PNSE      = 1'b0;
    end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb/tb_apb_rr_master_arbiter.sv - directed self-checking bench for apb_rr_master_arbiter
module tb_apb_rr_master_arbiter;
    import apb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    logic [NREQ-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*SW-1:0] req_strb;
    logic [DW-1:0]      rsp_rdata, PWDATA, PRDATA;
    logic               rsp_err, PNSE, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]      PADDR;
    logic [2:0]         PPROT;
    logic [SW-1:0]      PSTRB;

    // second instance with the timeout disabled and a slave that never answers
    logic [NREQ-1:0]    nt_req_valid, nt_req_ready, nt_req_write, nt_rsp_valid;
    logic [NREQ*AW-1:0] nt_req_addr;
    logic [NREQ*DW-1:0] nt_req_wdata;
    logic [NREQ*SW-1:0] nt_req_strb;
    logic [DW-1:0]      nt_rsp_rdata, nt_PWDATA;
    logic               nt_rsp_err, nt_PNSE, nt_PSEL, nt_PENABLE, nt_PWRITE;
    logic [AW-1:0]      nt_PADDR;
    logic [2:0]         nt_PPROT;
    logic [SW-1:0]      nt_PSTRB;

    int n_vec = 0;
    int n_err = 0;

    apb_rr_master_arbiter #(.AW(AW), .DW(DW), .SW(SW), .NREQ(NREQ), .TIMEOUT(16), .PROT_VAL(3'b000)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PPROT(PPROT), .PNSE(PNSE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_rr_master_arbiter #(.AW(AW), .DW(DW), .SW(SW), .NREQ(NREQ), .TIMEOUT(0), .PROT_VAL(3'b000)) dut_nt (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(nt_req_valid), .req_ready(nt_req_ready), .req_write(nt_req_write),
        .req_addr(nt_req_addr), .req_wdata(nt_req_wdata), .req_strb(nt_req_strb),
        .rsp_valid(nt_rsp_valid), .rsp_rdata(nt_rsp_rdata), .rsp_err(nt_rsp_err),
        .PADDR(nt_PADDR), .PPROT(nt_PPROT), .PNSE(nt_PNSE), .PSEL(nt_PSEL), .PENABLE(nt_PENABLE),
        .PWRITE(nt_PWRITE), .PWDATA(nt_PWDATA), .PSTRB(nt_PSTRB),
        .PRDATA(32'h0), .PREADY(1'b0), .PSLVERR(1'b0)
    );

    // Slave model: 16-word window at APB_REG_BASE, word 3 is a read-only ID,
    // cfg_wait wait states per access, PSLVERR outside the window.
    logic [31:0] mem [16];
    int          cfg_wait = 0;
    bit          force_nr = 1'b0;
    int          slv_cnt  = 0;
    logic        in_map;

    assign in_map  = (PADDR & 32'hFFFF_F000) == APB_REG_BASE;
    assign PREADY  = !force_nr && PSEL && PENABLE && (slv_cnt >= cfg_wait);
    assign PSLVERR = PREADY && !in_map;
    assign PRDATA  = !in_map ? 32'hBAD0_0BAD : (PADDR[5:2] == 4'd3) ? 32'hA735_0001 : mem[PADDR[5:2]];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
        if (!PRESETn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (PSEL && PENABLE && PREADY && PWRITE && in_map) begin
            for (int b = 0; b < 4; b++)
                if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    // Runs one transfer on requester r and reports what the bus and response did.
    task automatic do_xfer(input int r, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           output int lat, output int acc, output logic [31:0] rd,
                           output logic err, output logic [NREQ-1:0] rv,
                           output logic [NREQ-1:0] rdy, output bit stable,
                           output logic [3:0] strb_seen, output logic psel_at_rsp,
                           output bit done);
        int n;
        logic [31:0] a0, d0;
        logic w0;
        logic [3:0] s0;
        lat = 0; acc = 0; rd = '0; err = 1'b0; rv = '0; stable = 1'b1;
        strb_seen = '0; psel_at_rsp = 1'b0; done = 1'b0;
        @(negedge PCLK);
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW]  = addr;
        req_wdata[r*DW +: DW] = wd;
        req_strb[r*SW +: SW]  = st;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(negedge PCLK); #1; n++;
        end
        rdy = req_ready;
        if (!req_ready[r]) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(negedge PCLK);
        req_valid[r] = 1'b0;
        lat = 1;
        a0 = PADDR; w0 = PWRITE; d0 = PWDATA; s0 = PSTRB; strb_seen = PSTRB;
        while (lat < 40) begin
            if (rsp_valid != '0) begin
                done = 1'b1; rv = rsp_valid; rd = rsp_rdata; err = rsp_err; psel_at_rsp = PSEL;
                break;
            end
            if (PSEL && (PADDR !== a0 || PWRITE !== w0 || PWDATA !== d0 || PSTRB !== s0)) stable = 1'b0;
            if (PSEL && PENABLE) acc++;
            @(negedge PCLK);
            lat++;
        end
    endtask

    int lat, acc;
    logic [31:0] rd;
    logic err, psr;
    logic [NREQ-1:0] rv, rdy;
    bit stable, done;
    logic [3:0] sseen;

    task automatic test_reset();
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        nt_req_valid = '0; nt_req_write = '0; nt_req_addr = '0; nt_req_wdata = '0; nt_req_strb = '0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        n_vec++;
        if ({PSEL, PENABLE, PWRITE, PNSE, rsp_err} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b want=00000", {PSEL, PENABLE, PWRITE, PNSE, rsp_err});
        end
        n_vec++;
        if ({req_ready, rsp_valid} !== 4'b0) begin
            n_err++; $display("FAIL reset_handshake got=%b want=0000", {req_ready, rsp_valid});
        end
        n_vec++;
        if ({PADDR, PWDATA, PSTRB, PPROT} !== 71'b0 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_bus got addr=%h wdata=%h strb=%h prot=%b rdata=%h want all 0",
                              PADDR, PWDATA, PSTRB, PPROT, rsp_rdata);
        end
        // first grant after reset goes to requester 0; dropping before the edge starts nothing
        req_valid = 2'b11;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL reset_first_grant got=%b want=01", req_ready);
        end
        #1;
        req_valid = 2'b00;
        @(negedge PCLK);
        n_vec++;
        if (PSEL !== 1'b0) begin
            n_err++; $display("FAIL drop_before_grant PSEL got=%b want=0", PSEL);
        end
    endtask

    task automatic test_round_robin();
        int rem0, rem1, ng, nr;
        logic [NREQ-1:0] gr [6];
        logic [NREQ-1:0] ro [6];
        logic [31:0]     rdat [6];
        logic [NREQ-1:0] want;
        rem0 = 3; rem1 = 3; ng = 0; nr = 0;
        cfg_wait = 0;
        req_write = 2'b00;
        req_addr  = {APB_REG_BASE + 32'hC, APB_REG_BASE + 32'hC};
        for (int c = 0; c < 100 && nr < 6; c++) begin
            @(negedge PCLK);
            if (rsp_valid != '0 && nr < 6) begin
                ro[nr] = rsp_valid; rdat[nr] = rsp_rdata; nr++;
            end
            req_valid = {rem1 > 0, rem0 > 0};
            #1;
            if (req_ready != '0 && ng < 6) begin
                gr[ng] = req_ready; ng++;
                if (req_ready[0]) rem0--; else rem1--;
            end
        end
        req_valid = '0;
        n_vec++;
        if (ng != 6 || nr != 6) begin
            n_err++; $display("FAIL rr_counts grants=%0d rsps=%0d want 6/6", ng, nr);
        end
        for (int i = 0; i < 6; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if (i < ng && gr[i] !== want) begin
                n_err++; $display("FAIL rr_grant[%0d] got=%b want=%b", i, gr[i], want);
            end
            n_vec++;
            if (i < nr && (ro[i] !== want || rdat[i] !== 32'hA735_0001)) begin
                n_err++; $display("FAIL rr_rsp[%0d] got=%b/%h want=%b/a7350001", i, ro[i], rdat[i], want);
            end
        end
    endtask

    task automatic test_write_read();
        cfg_wait = 0;
        do_xfer(0, 1'b1, APB_REG_BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        n_vec++;
        if (!done || rdy !== 2'b01 || rv !== 2'b01 || lat != 3) begin
            n_err++; $display("FAIL wr_handshake done=%0d ready=%b rsp=%b lat=%0d want 1/01/01/3", done, rdy, rv, lat);
        end
        n_vec++;
        if (!stable || sseen !== 4'hF || rd !== 32'h0 || err !== 1'b0) begin
            n_err++; $display("FAIL wr_bus stable=%0d strb=%h rdata=%h err=%b want 1/f/0/0", stable, sseen, rd, err);
        end
        cfg_wait = 2;
        do_xfer(0, 1'b0, APB_REG_BASE + 32'h10, 32'h0, 4'hF, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        n_vec++;
        if (!done || rv !== 2'b01 || lat != 5 || acc != 3) begin
            n_err++; $display("FAIL rd_timing done=%0d rsp=%b lat=%0d acc=%0d want 1/01/5/3", done, rv, lat, acc);
        end
        n_vec++;
        if (rd !== 32'hDEAD_BEEF || err !== 1'b0 || !stable || sseen !== 4'h0) begin
            n_err++; $display("FAIL rd_data rdata=%h err=%b stable=%0d strb=%h want deadbeef/0/1/0", rd, err, stable, sseen);
        end
    endtask

    task automatic test_strobe_zero();
        cfg_wait = 1;
        do_xfer(0, 1'b1, APB_REG_BASE + 32'h4, 32'h1234_5678, 4'h0, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        n_vec++;
        if (!done || sseen !== 4'h0 || lat != 4) begin
            n_err++; $display("FAIL strb0_write done=%0d strb=%h lat=%0d want 1/0/4", done, sseen, lat);
        end
        do_xfer(0, 1'b0, APB_REG_BASE + 32'h4, 32'h0, 4'hF, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        n_vec++;
        if (!done || sseen !== 4'h0 || rd !== 32'h1000_0001) begin
            n_err++; $display("FAIL strb0_read done=%0d strb=%h rdata=%h want 1/0/10000001", done, sseen, rd);
        end
    endtask

    task automatic test_slverr();
        cfg_wait = 0;
        do_xfer(0, 1'b0, 32'h5000_0000, 32'h0, 4'h0, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        n_vec++;
        if (!done || err !== 1'b1 || rv !== 2'b01) begin
            n_err++; $display("FAIL slverr done=%0d err=%b rsp=%b want 1/1/01", done, err, rv);
        end
        do_xfer(0, 1'b0, APB_REG_BASE + 32'h10, 32'h0, 4'h0, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        n_vec++;
        if (!done || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL after_slverr done=%0d err=%b rdata=%h want 1/0/deadbeef", done, err, rd);
        end
    endtask

    task automatic test_timeout();
        force_nr = 1'b1;
        do_xfer(0, 1'b0, APB_REG_BASE + 32'h10, 32'h0, 4'h0, lat, acc, rd, err, rv, rdy, stable, sseen, psr, done);
        force_nr = 1'b0;
        n_vec++;
        if (!done || acc != 16 || lat != 18) begin
            n_err++; $display("FAIL timeout_len done=%0d access=%0d lat=%0d want 1/16/18", done, acc, lat);
        end
        n_vec++;
        if (err !== 1'b1 || rd !== 32'h0 || psr !== 1'b0 || rv !== 2'b01) begin
            n_err++; $display("FAIL timeout_rsp err=%b rdata=%h psel=%b rsp=%b want 1/0/0/01", err, rd, psr, rv);
        end
    endtask

    task automatic test_no_timeout();
        int n, nacc, nrsp;
        @(negedge PCLK);
        nt_req_valid = 2'b01;
        nt_req_addr  = {32'h0, APB_REG_BASE + 32'h10};
        #1;
        n = 0;
        while (!nt_req_ready[0] && n < 20) begin
            @(negedge PCLK); #1; n++;
        end
        n_vec++;
        if (nt_req_ready !== 2'b01) begin
            n_err++; $display("FAIL nt_accept got=%b want=01", nt_req_ready);
        end
        @(negedge PCLK);
        nt_req_valid = 2'b00;
        nacc = 0; nrsp = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK);
            if (nt_PSEL && nt_PENABLE) nacc++;
            if (nt_rsp_valid != '0) nrsp++;
        end
        n_vec++;
        if (nacc != 40 || nrsp != 0) begin
            n_err++; $display("FAIL nt_stuck access=%0d rsps=%0d want 40/0", nacc, nrsp);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        logic [NREQ-1:0] first_rsp, g;
        cfg_wait = 6;
        @(negedge PCLK);
        req_write = 2'b00;
        req_addr  = {APB_REG_BASE + 32'hC, APB_REG_BASE + 32'hC};
        req_valid = 2'b01;
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(negedge PCLK); #1; n++;
        end
        @(negedge PCLK);
        req_valid = 2'b10;
        n = 0;
        while (!PENABLE && n < 10) begin
            @(negedge PCLK); n++;
        end
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        n_vec++;
        if ({PSEL, PENABLE, rsp_valid} !== 4'b0) begin
            n_err++; $display("FAIL abort_outputs got=%b want=0000", {PSEL, PENABLE, rsp_valid});
        end
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL abort_pending_grant got=%b want=10", req_ready);
        end
        @(negedge PCLK);
        req_valid = 2'b01;
        first_rsp = '0; g = '0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid != '0 && first_rsp == '0) first_rsp = rsp_valid;
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
            @(negedge PCLK); #1;
        end
        n_vec++;
        if (first_rsp !== 2'b10 || g !== 2'b01) begin
            n_err++; $display("FAIL abort_order first_rsp=%b next_grant=%b want 10/01", first_rsp, g);
        end
        @(negedge PCLK);
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid == '0 && n < 30) begin
            @(negedge PCLK); n++;
        end
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hA735_0001 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL abort_req0_rsp rsp=%b rdata=%h err=%b want 01/a7350001/0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_strobe_zero();
        test_slverr();
        test_timeout();
        test_no_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
